// File: rtl/hack_pkg.sv
// Hack CPU shared definitions: instruction field positions, ALU op bit
// indices and jump encodings. Imported by the control stage and jump unit.
package hack_pkg;
   // instruction field positions
   localparam int IS_C    = 15;
   localparam int A_SEL   = 12;
   localparam int CMP_HI  = 11;
   localparam int CMP_LO  = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JMP_HI  = 2;
   localparam int JMP_LO  = 0;

   // ALU op bit indices: op = {no,f,ny,zy,nx,zx}
   localparam int OP_ZX = 0;
   localparam int OP_NX = 1;
   localparam int OP_ZY = 2;
   localparam int OP_NY = 3;
   localparam int OP_F  = 4;
   localparam int OP_NO = 5;

   typedef enum logic [2:0] {
      JNULL = 3'b000,
      JGT   = 3'b001,
      JEQ   = 3'b010,
      JGE   = 3'b011,
      JLT   = 3'b100,
      JNE   = 3'b101,
      JLE   = 3'b110,
      JMP   = 3'b111
   } jmp_e;

   // Comp field is instr[11:6] = {zx,nx,zy,ny,f,no}; the ALU wants it reversed.
   function automatic logic [5:0] cmp_to_op(input logic [5:0] cmp);
      logic [5:0] op;
      op[OP_ZX] = cmp[5];
      op[OP_NX] = cmp[4];
      op[OP_ZY] = cmp[3];
      op[OP_NY] = cmp[2];
      op[OP_F]  = cmp[1];
      op[OP_NO] = cmp[0];
      return op;
   endfunction
endpackage

// File: rtl/hack_jump_unit.sv
// Hack jump decision.
//  jmp_i  : instr[2:0] jump bits {lt,eq,gt}
//  zr_i   : ALU result == 0
//  ng_i   : ALU result < 0
//  take_o : branch taken
module hack_jump_unit
   import hack_pkg::*;
(
   input  logic [2:0] jmp_i,
   input  logic       zr_i,
   input  logic       ng_i,
   output logic       take_o
);
   assign take_o = (jmp_i[2] & ng_i) | (jmp_i[1] & zr_i) | (jmp_i[0] & ~zr_i & ~ng_i);
endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU register/control stage: holds A, D, PC; decodes A/C instructions;
// drives an external ALU combinationally and retires one instruction per
// advancing cycle.
//  clk, rst              : clock, async active-high reset
//  instr, instr_valid    : instruction at pc
//  stall                 : data memory busy, hold state
//  inM                   : data memory read value at addressM
//  alu_x/alu_y/alu_op    : ALU operands and control {no,f,ny,zy,nx,zx}
//  alu_result/zr/ng      : ALU result and flags
//  outM/writeM/addressM  : data memory write port
//  pc                    : fetch address
//  halted                : sticky, set by unconditional self-jump
module hack_cpu_ctrl
   import hack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int PC_W  = 15,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_valid,
   input  logic             stall,
   input  logic [WIDTH-1:0] inM,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zr,
   input  logic             alu_ng,
   output logic [WIDTH-1:0] outM,
   output logic             writeM,
   output logic [PC_W-1:0]  addressM,
   output logic [PC_W-1:0]  pc,
   output logic             halted
);
   logic [WIDTH-1:0] a_q, a_d, d_q, d_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             halted_q, halted_d;
   logic             advance, is_c, take;

   assign advance = instr_valid & ~stall & ~halted_q;
   assign is_c    = instr[IS_C];

   assign alu_x    = d_q;
   assign alu_y    = instr[A_SEL] ? inM : a_q;
   assign alu_op   = cmp_to_op(instr[CMP_HI:CMP_LO]);
   assign outM     = alu_result;
   // rst gating keeps the strobe low even while the async reset is asserted
   assign writeM   = advance & is_c & instr[DEST_M] & ~rst;
   assign addressM = a_q[PC_W-1:0];
   assign pc       = pc_q;
   assign halted   = halted_q;

   hack_jump_unit u_jump (
      .jmp_i  (instr[JMP_HI:JMP_LO]),
      .zr_i   (alu_zr),
      .ng_i   (alu_ng),
      .take_o (take)
   );

   always_comb begin
      a_d      = a_q;
      d_d      = d_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      if (advance) begin
         if (!is_c) begin
            a_d  = WIDTH'(instr[14:0]);
            pc_d = pc_q + PC_W'(1);
         end else begin
            if (instr[DEST_A]) a_d = alu_result;
            if (instr[DEST_D]) d_d = alu_result;
            // jump target is the A value from before this cycle's writeback
            pc_d = take ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
            if (instr[JMP_HI:JMP_LO] == JMP && a_q[PC_W-1:0] == pc_q)
               halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         d_q      <= '0;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         d_q      <= d_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        stall;
   logic [15:0] inM;
   logic [15:0] alu_x, alu_y, alu_result;
   logic [5:0]  alu_op;
   logic        alu_zr, alu_ng;
   logic [15:0] outM;
   logic        writeM;
   logic [14:0] addressM, pc;
   logic        halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hack_cpu_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .stall(stall), .inM(inM), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc), .halted(halted)
   );

   // Hack ALU, op = {no,f,ny,zy,nx,zx}
   logic [15:0] ax, ay, ao;
   always_comb begin
      ax = alu_op[0] ? 16'h0 : alu_x;
      ax = alu_op[1] ? ~ax : ax;
      ay = alu_op[2] ? 16'h0 : alu_y;
      ay = alu_op[3] ? ~ay : ay;
      ao = alu_op[4] ? ax + ay : ax & ay;
      ao = alu_op[5] ? ~ao : ao;
   end
   assign alu_result = ao;
   assign alu_zr     = (ao == 16'h0);
   assign alu_ng     = ao[15];

   // apply one valid instruction and clock it in
   task automatic exec(input logic [15:0] ins);
      instr = ins; instr_valid = 1'b1; stall = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; instr = 16'hE308; instr_valid = 1'b1; stall = 1'b0; inM = 16'h0;
      #1;
      checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM got=%0b exp=0", writeM); end
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b0; instr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pc !== 15'h0 || addressM !== 15'h0 || alu_x !== 16'h0 || writeM !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle%0d got pc=%h A=%h D=%h wM=%b h=%b exp all 0", i, pc, addressM, alu_x, writeM, halted);
         end
      end
   endtask

   task automatic test_datapath();
      exec(16'h0002);
      exec(16'hEC10);
      checks++; if (alu_x !== 16'h0002) begin errors++; $display("FAIL d_eq_a got=%h exp=0002", alu_x); end
      exec(16'h0003);
      exec(16'hE090);
      checks++; if (alu_x !== 16'h0005) begin errors++; $display("FAIL d_plus_a got=%h exp=0005", alu_x); end
      exec(16'h0000);
      instr = 16'hE308; instr_valid = 1'b1; #1;
      checks++;
      if (writeM !== 1'b1 || addressM !== 15'h0 || outM !== 16'h0005) begin
         errors++; $display("FAIL m_eq_d got wM=%b addr=%h out=%h exp 1/0000/0005", writeM, addressM, outM);
      end
      @(posedge clk); #1;
      checks++; if (pc !== 15'd6) begin errors++; $display("FAIL pc_seq got=%0d exp=6", pc); end
   endtask

   task automatic test_jump();
      exec(16'h0007);
      exec(16'hEE90);
      checks++; if (alu_x !== 16'hFFFF) begin errors++; $display("FAIL d_m1 got=%h exp=ffff", alu_x); end
      exec(16'hE304);
      checks++; if (pc !== 15'd7) begin errors++; $display("FAIL jlt_taken got=%0d exp=7", pc); end
      exec(16'hEA90);
      exec(16'hE304);
      checks++; if (pc !== 15'd9) begin errors++; $display("FAIL jlt_not_taken got=%0d exp=9", pc); end
   endtask

   task automatic test_stall();
      exec(16'h0005);
      inM = 16'h1234; instr = 16'hFC20; instr_valid = 1'b1; stall = 1'b1;
      #1;
      checks++; if (alu_y !== 16'h1234) begin errors++; $display("FAIL y_sel_m got=%h exp=1234", alu_y); end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (addressM !== 15'h0005 || pc !== 15'd10) begin
         errors++; $display("FAIL stall_hold got A=%h pc=%0d exp 0005/10", addressM, pc);
      end
      instr_valid = 1'b0; @(posedge clk); #1;
      checks++;
      if (addressM !== 15'h0005 || pc !== 15'd10) begin
         errors++; $display("FAIL stall_novalid_hold got A=%h pc=%0d exp 0005/10", addressM, pc);
      end
      instr_valid = 1'b1; stall = 1'b0; @(posedge clk); #1;
      checks++;
      if (addressM !== 15'h1234 || pc !== 15'd11) begin
         errors++; $display("FAIL stall_release got A=%h pc=%0d exp 1234/11", addressM, pc);
      end
   endtask

   task automatic test_wrap();
      exec(16'h7FFF);
      exec(16'hEA87);
      checks++; if (pc !== 15'h7FFF || halted !== 1'b0) begin errors++; $display("FAIL jmp_top got pc=%h h=%b exp 7fff/0", pc, halted); end
      exec(16'h0001);
      checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL pc_wrap got=%h exp=0000", pc); end
   endtask

   task automatic test_halt();
      exec(16'h0000); exec(16'h0000); exec(16'h0000);
      checks++; if (pc !== 15'd3) begin errors++; $display("FAIL pre_halt_pc got=%0d exp=3", pc); end
      exec(16'h0004);
      exec(16'hEA87);
      checks++; if (halted !== 1'b1 || pc !== 15'd4) begin errors++; $display("FAIL halt_set got h=%b pc=%0d exp 1/4", halted, pc); end
      exec(16'h0009);
      checks++; if (pc !== 15'd4 || addressM !== 15'd4) begin errors++; $display("FAIL halt_ignore got pc=%0d A=%0d exp 4/4", pc, addressM); end
      instr = 16'hE308; #1;
      checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL halt_nowrite got=%b exp=0", writeM); end
      @(negedge clk); rst = 1'b1; #1;
      checks++; if (halted !== 1'b0 || pc !== 15'd0) begin errors++; $display("FAIL halt_reset got h=%b pc=%0d exp 0/0", halted, pc); end
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_datapath();
      test_jump();
      test_stall();
      test_wrap();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
